// File: rtl/io_reg_deser_if.sv
// Word output bus of the serial-to-parallel input stage: assembled word
// plus its valid/ready handshake.
interface io_reg_deser_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] WORD_DATA;
  logic             WORD_VALID;
  logic             WORD_READY;

  modport master (
    output WORD_DATA,
    output WORD_VALID,
    input  WORD_READY
  );

  modport slave (
    input  WORD_DATA,
    input  WORD_VALID,
    output WORD_READY
  );
endinterface

// File: rtl/io_reg_deser.sv
// Serial-to-parallel input stage fed by the 1-bit IO input register.
// Assembles WIDTH-bit words (first bit in MSB), supports pattern-based
// alignment (HUNT -> LOCK), manual bit slip, and a single-entry output
// holding register with a sticky overflow flag.
module io_reg_deser #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ALIGN_PAT = 8'hA5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          D,
  input  logic          EN,
  input  logic          ALIGN,
  input  logic          BITSLIP,
  input  logic          CLR_OVF,
  output logic          LOCKED,
  output logic          OVERFLOW,
  io_reg_deser_if.master word
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             slip_pend;
  logic             slip_next;
  logic             word_done;
  logic [WIDTH-1:0] window;

  // The candidate word is always the stored history plus the bit on D.
  assign window = {sr, D};

  // Next state, bit counter, pending slip and word-complete strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    slip_next  = slip_pend;
    word_done  = 1'b0;
    if (ALIGN) begin
      state_next = HUNT;
      cnt_next   = '0;
      slip_next  = 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (EN && (window == ALIGN_PAT)) begin
            state_next = LOCK;
            cnt_next   = '0;
          end
        end
        default: begin
          if (EN && slip_pend) begin
            slip_next = 1'b0;
          end else begin
            if (BITSLIP) begin
              slip_next = 1'b1;
            end
            if (EN) begin
              if (cnt == CNT_MAX) begin
                word_done = 1'b1;
                cnt_next  = '0;
              end else begin
                cnt_next = cnt + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // Control registers; LOCKED is a dedicated flop so the output is glitch-free.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FREE;
      cnt       <= '0;
      slip_pend <= 1'b0;
      LOCKED    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      slip_pend <= slip_next;
      LOCKED    <= (state_next == LOCK);
    end
  end

  // Bit history shifts on every enabled bit regardless of state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr <= '0;
    end else if (EN) begin
      sr <= window[WIDTH-2:0];
    end
  end

  // Single-entry output holding register; a word arriving while the
  // previous one is still unaccepted is dropped and flagged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word.WORD_DATA  <= '0;
      word.WORD_VALID <= 1'b0;
      OVERFLOW        <= 1'b0;
    end else begin
      if (word_done) begin
        if (!word.WORD_VALID || word.WORD_READY) begin
          word.WORD_DATA  <= window;
          word.WORD_VALID <= 1'b1;
        end
      end else if (word.WORD_VALID && word.WORD_READY) begin
        word.WORD_VALID <= 1'b0;
      end
      if (word_done && word.WORD_VALID && !word.WORD_READY) begin
        OVERFLOW <= 1'b1;
      end else if (CLR_OVF) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_reg_deser.sv
// Scoreboard testbench for io_reg_deser: directed bit streams push expected
// words into a queue; a monitor pops and compares on every accepted word.
module tb_io_reg_deser;

  logic clk;
  logic rst;
  logic d;
  logic en;
  logic align;
  logic bitslip;
  logic clr_ovf;
  logic locked;
  logic overflow;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  io_reg_deser_if #(.WIDTH(8)) word_bus ();

  io_reg_deser #(
    .WIDTH(8),
    .ALIGN_PAT(8'hA5)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .D(d),
    .EN(en),
    .ALIGN(align),
    .BITSLIP(bitslip),
    .CLR_OVF(clr_ovf),
    .LOCKED(locked),
    .OVERFLOW(overflow),
    .word(word_bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: each accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && word_bus.WORD_VALID && word_bus.WORD_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_word: actual=%h required=none", word_bus.WORD_DATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (word_bus.WORD_DATA !== e) begin
          failures++;
          $display("[TB] FAIL word_data: actual=%h required=%h", word_bus.WORD_DATA, e);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    d  = b;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle_cycle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] w, input bit expect_word);
    if (expect_word) exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    d        = 1'b0;
    en       = 1'b0;
    align    = 1'b0;
    bitslip  = 1'b0;
    clr_ovf  = 1'b0;
    word_bus.WORD_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_data", 32'(word_bus.WORD_DATA), 32'h00);
    check_output("reset_valid", 32'(word_bus.WORD_VALID), 32'h0);
    check_output("reset_locked", 32'(locked), 32'h0);
    check_output("reset_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;

    // Basic word B2, valid for exactly one cycle.
    apply_stimulus(8'hB2, 1'b1);
    check_output("basic_valid", 32'(word_bus.WORD_VALID), 32'h1);
    check_output("basic_data", 32'(word_bus.WORD_DATA), 32'hB2);
    check_output("basic_locked", 32'(locked), 32'h0);
    idle_cycle();
    check_output("basic_valid_drop", 32'(word_bus.WORD_VALID), 32'h0);

    // Overflow: second word dropped while first is held.
    word_bus.WORD_READY = 1'b0;
    apply_stimulus(8'h11, 1'b1);
    check_output("ovf_first_no_ovf", 32'(overflow), 32'h0);
    apply_stimulus(8'h22, 1'b0);
    check_output("ovf_data_kept", 32'(word_bus.WORD_DATA), 32'h11);
    check_output("ovf_flag", 32'(overflow), 32'h1);
    check_output("ovf_valid", 32'(word_bus.WORD_VALID), 32'h1);
    clr_ovf = 1'b1;
    idle_cycle();
    clr_ovf = 1'b0;
    check_output("ovf_cleared", 32'(overflow), 32'h0);
    check_output("ovf_valid_held", 32'(word_bus.WORD_VALID), 32'h1);
    word_bus.WORD_READY = 1'b1;
    idle_cycle();
    check_output("ovf_drained", 32'(word_bus.WORD_VALID), 32'h0);

    // Simultaneous accept of held word and completion of 5A.
    word_bus.WORD_READY = 1'b0;
    apply_stimulus(8'h96, 1'b1);
    exp_q.push_back(8'h5A);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h5A >> i));
    word_bus.WORD_READY = 1'b1;
    send_bit(1'b0);
    check_output("simul_data", 32'(word_bus.WORD_DATA), 32'h5A);
    check_output("simul_valid", 32'(word_bus.WORD_VALID), 32'h1);
    check_output("simul_ovf", 32'(overflow), 32'h0);
    idle_cycle();
    check_output("simul_valid_drop", 32'(word_bus.WORD_VALID), 32'h0);

    // Alignment: junk, then A5 pattern (not emitted), then 3C.
    align = 1'b1;
    idle_cycle();
    align = 1'b0;
    check_output("hunt_locked", 32'(locked), 32'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i));
    check_output("hunt_not_yet_locked", 32'(locked), 32'h0);
    send_bit(1'b1);
    check_output("lock_locked", 32'(locked), 32'h1);
    check_output("lock_no_valid", 32'(word_bus.WORD_VALID), 32'h0);
    apply_stimulus(8'h3C, 1'b1);
    check_output("lock_first_word", 32'(word_bus.WORD_DATA), 32'h3C);

    // Bit slip: stream 3C, slip once (second pulse while pending ignored).
    apply_stimulus(8'h3C, 1'b1);
    bitslip = 1'b1;
    idle_cycle();
    idle_cycle();
    bitslip = 1'b0;
    repeat (3) exp_q.push_back(8'h78);
    apply_stimulus(8'h3C, 1'b0);
    apply_stimulus(8'h3C, 1'b0);
    apply_stimulus(8'h3C, 1'b0);
    send_bit(1'b0);
    check_output("slip_data", 32'(word_bus.WORD_DATA), 32'h78);
    check_output("slip_locked", 32'(locked), 32'h1);
    idle_cycle();

    // Asynchronous reset mid-word, then a clean C3.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #1 rst = 1'b1;
    #1;
    check_output("rst_async_data", 32'(word_bus.WORD_DATA), 32'h00);
    check_output("rst_async_valid", 32'(word_bus.WORD_VALID), 32'h0);
    check_output("rst_async_locked", 32'(locked), 32'h0);
    check_output("rst_async_ovf", 32'(overflow), 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(8'hC3, 1'b1);
    check_output("post_rst_data", 32'(word_bus.WORD_DATA), 32'hC3);
    check_output("post_rst_valid", 32'(word_bus.WORD_VALID), 32'h1);
    check_output("post_rst_locked", 32'(locked), 32'h0);

    repeat (4) idle_cycle();
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
